// File: rtl/cmp_seq.sv
`default_nettype none
// ============================================================================
// Module   : cmp_seq
// Purpose  : Sequential magnitude comparator. Compares two WIDTH-bit operands
//            CHUNK bits per cycle, MSB slice first. It produces unsigned,
//            signed (two's complement) and equality flags after a fixed
//            latency of N = WIDTH/CHUNK cycles.
// Ports    : clk   - clock; all state changes on its rising edge
//            rstn  - synchronous active-low reset
//            start - request a compare; accepted only while busy=0
//            x, y  - operands, sampled on the accepting edge
//            busy  - compare in progress
//            done  - one-cycle pulse; result flags were updated this cycle
//            ug/ul - x > y / x < y, unsigned
//            eq    - x == y
//            sg/sl - x > y / x < y, signed
// Revision : 1.0 - initial release
// ============================================================================
module cmp_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             ug,
  output logic             ul,
  output logic             eq,
  output logic             sg,
  output logic             sl
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // Reject illegal parameter combinations at elaboration time.
  if (WIDTH < 4 || WIDTH > 64 || CHUNK < 1 || CHUNK > WIDTH ||
      (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("cmp_seq: illegal WIDTH/CHUNK combination");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // The latched operands shift left by one slice per RUN cycle. The slice
  // under test therefore always sits in the top CHUNK bits. The sign bits
  // are captured separately because the shift destroys them.
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic             sign_x;
  logic             sign_y;
  logic [CNT_W-1:0] cnt;
  logic             decided;  // a differing slice has already been seen
  logic             gt;       // unsigned verdict once decided (1: x > y)

  logic             accept;
  logic             finish;
  logic [CHUNK-1:0] slice_x;
  logic [CHUNK-1:0] slice_y;
  logic             decided_next;
  logic             gt_next;

  assign slice_x = x_r[WIDTH-1 -: CHUNK];
  assign slice_y = y_r[WIDTH-1 -: CHUNK];

  // The first differing slice from the MSB end fixes the verdict. Later
  // slices cannot override it.
  assign decided_next = decided | (slice_x != slice_y);
  assign gt_next      = decided ? gt : (slice_x > slice_y);

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      x_r     <= '0;
      y_r     <= '0;
      sign_x  <= 1'b0;
      sign_y  <= 1'b0;
      cnt     <= '0;
      decided <= 1'b0;
      gt      <= 1'b0;
      done    <= 1'b0;
      ug      <= 1'b0;
      ul      <= 1'b0;
      eq      <= 1'b0;
      sg      <= 1'b0;
      sl      <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        x_r     <= x;
        y_r     <= y;
        sign_x  <= x[WIDTH-1];
        sign_y  <= y[WIDTH-1];
        cnt     <= CNT_LAST;
        decided <= 1'b0;
        gt      <= 1'b0;
      end else if (state == RUN) begin
        x_r     <= x_r << CHUNK;
        y_r     <= y_r << CHUNK;
        decided <= decided_next;
        gt      <= gt_next;
        if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end
      end

      if (finish) begin
        eq <= ~decided_next;
        ug <= decided_next & gt_next;
        ul <= decided_next & ~gt_next;
        // Opposite signs settle the signed order directly. With equal
        // signs, the signed order is the same as the unsigned order.
        if (sign_x != sign_y) begin
          sg <= ~sign_x;
          sl <= sign_x;
        end else begin
          sg <= decided_next & gt_next;
          sl <= decided_next & ~gt_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_seq
// Purpose  : Self-checking bench for cmp_seq (WIDTH=16, CHUNK=4). Stimulus
//            pushes the hand-computed flag vector {ug,ul,eq,sg,sl} into a
//            queue. A monitor pops and compares it on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_seq;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [15:0] x;
  logic [15:0] y;
  logic        busy;
  logic        done;
  logic        ug;
  logic        ul;
  logic        eq;
  logic        sg;
  logic        sl;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];
  logic [4:0] hold_exp;  // flags expected between done pulses

  cmp_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .ug    (ug),
    .ul    (ul),
    .eq    (eq),
    .sg    (sg),
    .sl    (sl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] flags();
    return {11'd0, ug, ul, eq, sg, sl};
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rstn && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done with flags %b, required no done", flags());
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if (flags() !== {11'd0, e}) begin
          errors++;
          $display("FAIL done_flags: got %b, required %b", flags(), e);
        end
      end
    end
  end

  // One compare with the expected fixed timing. If glitch is set, start is
  // pulsed again mid-RUN with different operands, and x/y are always
  // scrambled after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [4:0] e, input bit glitch);
    @(negedge clk);
    check("idle_before", {15'd0, busy}, 16'd0);
    x = a;
    y = b;
    start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    x = ~a;
    y = 16'h5A5A;
    for (int i = 0; i < 4; i++) begin
      check("busy_run", {14'd0, busy, done}, 16'h0002);
      check("flags_hold_run", flags(), {11'd0, hold_exp});
      if (glitch && i == 1) begin
        start = 1'b1;
        x = 16'h0000;
        y = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("done_time", {14'd0, busy, done}, 16'h0001);
    hold_exp = e;
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    x = 16'h0;
    y = 16'h0;
    hold_exp = 5'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {9'd0, busy, done, flags()[4:0]}, 16'h0000);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("flags_zero_after_reset", flags(), 16'h0000);

    //       x         y          {ug,ul,eq,sg,sl}
    send(16'h1234, 16'h1234, 5'b00100, 1'b0);
    send(16'h8000, 16'h0001, 5'b10001, 1'b0);
    send(16'h7FFF, 16'hFFFF, 5'b01010, 1'b0);
    send(16'h1235, 16'h1234, 5'b10010, 1'b0);
    send(16'h0F00, 16'h0E00, 5'b10010, 1'b1);
    send(16'h8000, 16'h8000, 5'b00100, 1'b0);
    send(16'hFFFE, 16'hFFFF, 5'b01001, 1'b0);
    send(16'h0005, 16'h0003, 5'b10010, 1'b0);

    // Reset on the 2nd RUN cycle, with start also high: no done pulse and
    // all flags clear.
    @(negedge clk);
    x = 16'h0001;
    y = 16'h0002;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_run", {9'd0, busy, done, flags()[4:0]}, 16'h0000);
    rstn = 1'b1;
    start = 1'b0;
    hold_exp = 5'b0;
    for (int i = 0; i < 6; i++) begin
      check("no_done_after_reset", {14'd0, busy, done}, 16'h0000);
      @(posedge clk);
      #1;
    end
    send(16'h0002, 16'h0001, 5'b10010, 1'b0);

    // Back-to-back: start held high. Accepts happen at cycles 0, 5 and 10.
    @(negedge clk);
    x = 16'hFFFF;
    y = 16'h0000;
    start = 1'b1;
    exp_q.push_back(5'b10001);
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        x = 16'h0000;
        y = 16'h0001;
        exp_q.push_back(5'b01001);
      end
      if (c == 5) begin
        x = 16'h4444;
        y = 16'h4444;
        exp_q.push_back(5'b00100);
      end
      if (c == 10) start = 1'b0;
      if (c == 4) hold_exp = 5'b10001;
      if (c == 9) hold_exp = 5'b01001;
      if (c == 14) hold_exp = 5'b00100;
      check("b2b_done", {15'd0, done}, {15'd0, (c % 5) == 4});
      check("b2b_flags", flags(), {11'd0, hold_exp});
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmp_seq.md
CMP_SEQ -- requirements
Module: cmp_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; legal values 4..64.
REQ-002 Parameter CHUNK, default 4: bits compared per cycle; legal values 1..WIDTH, and WIDTH SHALL be an exact multiple of CHUNK.
REQ-003 Derived constant N = WIDTH/CHUNK: number of compare cycles.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rstn  in  1  reset; synchronous, active-low.
REQ-006 start  in  1  request a compare; accepted only when busy=0.
REQ-007 x  in  WIDTH  operand A, sampled on the accepting edge.
REQ-008 y  in  WIDTH  operand B, sampled on the accepting edge.
REQ-009 busy  out  1  compare in progress.
REQ-010 done  out  1  one-cycle pulse: result flags updated this cycle.
REQ-011 ug  out  1  x > y, unsigned.
REQ-012 ul  out  1  x < y, unsigned.
REQ-013 eq  out  1  x == y.
REQ-014 sg  out  1  x > y, two's complement.
REQ-015 sl  out  1  x < y, two's complement.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE (busy=0) and RUN (busy=1).
REQ-017 In IDLE, start=1 at an edge SHALL latch x and y into internal registers, load the chunk counter with N-1, and enter RUN.
REQ-018 In RUN, each edge SHALL compare one CHUNK-bit slice of the latched operands, MSB slice first, and then decrement the counter.
REQ-019 The unsigned verdict SHALL be decided by the first differing slice from the MSB end; later slices SHALL NOT change that verdict; if no slice differs, the verdict is equal.
REQ-020 Latency SHALL be fixed: N edges in RUN, with no early exit, independent of operand values.
REQ-021 On the edge that processes slice 0 (counter = 0), the block SHALL return to IDLE, register all five flags, and drive done=1 for exactly that following cycle.
REQ-022 Signed verdict: if the operand sign bits (bit WIDTH-1) differ, then sg = ~x[WIDTH-1] and sl = x[WIDTH-1]; otherwise sg = ug and sl = ul.
REQ-023 After every completed compare, exactly one of {ug, ul, eq} SHALL be 1 and exactly one of {sg, sl, eq} SHALL be 1.
REQ-024 Flags SHALL hold their values from done until the next done or reset; they SHALL NOT change during RUN.
REQ-025 start while busy=1 SHALL be ignored: no re-latch and no effect on the in-flight result.
REQ-026 start=1 in the cycle where done=1 SHALL be accepted, since busy=0 in that cycle; the flags from the previous compare SHALL remain valid until the new done.
REQ-027 Changes on x and y after the accepting edge SHALL NOT affect the result.
REQ-028 N=1 (CHUNK=WIDTH) SHALL work: one RUN edge, so done occurs one cycle after acceptance.

Reset
REQ-029 rstn=0 at an edge SHALL force IDLE, busy=0, done=0, ug=ul=eq=sg=sl=0, and counter=0, regardless of state.
REQ-030 rstn=0 SHALL take priority over start.
REQ-031 A compare interrupted by reset SHALL produce no done pulse and no flag update.
REQ-032 Before the first completed compare after reset, all flags SHALL read 0.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-033 x=0x1234, y=0x1234, start for 1 cycle -> busy=1 for 4 cycles; done=1 on the 4th cycle after acceptance; eq=1; ug=ul=sg=sl=0.
REQ-034 x=0x8000, y=0x0001 -> ug=1, sl=1, eq=ul=sg=0.
REQ-035 x=0x7FFF, y=0xFFFF -> ul=1, sg=1; x=0x1235, y=0x1234 (differs in slice 0 only) -> ug=1, sg=1.
REQ-036 x=0x0F00, y=0x0E00 accepted; start re-pulsed mid-RUN with x=0, y=0xFFFF -> ignored; result ug=1, sg=1, done after 4 cycles.
REQ-037 rstn=0 on the 2nd RUN cycle -> busy=0 next cycle, all flags 0, no done pulse; a fresh start then completes normally.
REQ-038 start held high across done -> back-to-back compares; done pulses every 5 cycles; flags change only on done.
